// File: rtl/can_error_confinement.sv
// ---------------------------------------------------------------------------
// can_error_confinement
//
// CAN fault-confinement block, clocked once per bit at the sample point.
//
// What it does:
//   - Merges N_ERR active-low error-detect sources into one error event.
//   - Keeps the transmit and receive error counters (TEC/REC).
//   - Derives the error-active, error-passive and bus-off state.
//   - Sequences the error flag, flag superposition and error delimiter on
//     the bus.
//   - Runs bus-off recovery, which needs RECOV_SEQ runs of 11 recessive
//     bits.
//
// Ports:
//   SP         in   sample-point clock, all state changes on its rising edge
//   reset      in   asynchronous active-high reset
//   err_n      in   [N_ERR] per-source error detect, active-low
//   is_tx      in   1 = node transmits the current frame, 0 = receiver
//   tx_ok      in   one-SP pulse, frame transmitted successfully
//   rx_ok      in   one-SP pulse, frame received successfully
//   bus_bit    in   sampled bus level, 0 = dominant
//   ERROR      out  active-low error pulse, one SP long
//   flag_bit   out  level to drive on the bus, 0 = dominant
//   err_src    out  [N_ERR] active-high copy of the sources of the last error
//   err_state  out  00 error-active, 01 error-passive, 10 bus-off
//   tec        out  [CNT_W] transmit error counter
//   rec        out  [CNT_W] receive error counter
// ---------------------------------------------------------------------------
module can_error_confinement #(
    parameter int N_ERR       = 4,
    parameter int FLAG_LEN    = 6,
    parameter int DELIM_LEN   = 8,
    parameter int CNT_W       = 9,
    parameter int PASSIVE_LIM = 128,
    parameter int BUSOFF_LIM  = 256,
    parameter int RECOV_SEQ   = 128
) (
    input  logic             SP,
    input  logic             reset,
    input  logic [N_ERR-1:0] err_n,
    input  logic             is_tx,
    input  logic             tx_ok,
    input  logic             rx_ok,
    input  logic             bus_bit,
    output logic             ERROR,
    output logic             flag_bit,
    output logic [N_ERR-1:0] err_src,
    output logic [1:0]       err_state,
    output logic [CNT_W-1:0] tec,
    output logic [CNT_W-1:0] rec
);

    localparam int FC_W    = (FLAG_LEN  > 1) ? $clog2(FLAG_LEN)  : 1;
    localparam int DC_W    = (DELIM_LEN > 1) ? $clog2(DELIM_LEN) : 1;
    localparam int OC_W    = (RECOV_SEQ > 1) ? $clog2(RECOV_SEQ) : 1;
    localparam int RUN_LEN = 11;
    localparam int RC_W    = 4;

    // Thresholds are compared one bit wider than the counters, so that a
    // limit equal to 2^CNT_W still works.
    localparam logic [CNT_W:0]   CNT_MAX     = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0]   PASSIVE_THR = (CNT_W+1)'(PASSIVE_LIM);
    localparam logic [CNT_W:0]   BUSOFF_THR  = (CNT_W+1)'(BUSOFF_LIM);
    localparam logic [CNT_W-1:0] REC_RESTORE = CNT_W'(119);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLAG,
        ST_SUPERPOS,
        ST_DELIM,
        ST_BUSOFF
    } state_t;

    state_t            state_reg,     state_next;
    logic [FC_W-1:0]   flag_cnt_reg,  flag_cnt_next;
    logic [DC_W-1:0]   delim_cnt_reg, delim_cnt_next;
    logic [RC_W-1:0]   run_cnt_reg,   run_cnt_next;
    logic [OC_W-1:0]   occ_cnt_reg,   occ_cnt_next;
    logic [CNT_W-1:0]  tec_reg,       tec_next;
    logic [CNT_W-1:0]  rec_reg,       rec_next;
    logic              busoff_reg,    busoff_next;
    logic              dom_flag_reg,  dom_flag_next;
    logic              error_n_reg,   error_n_next;
    logic [N_ERR-1:0]  err_src_reg,   err_src_next;

    logic [N_ERR-1:0]  src_active;
    logic              err_event;
    logic [CNT_W-1:0]  tec_inc;
    logic [CNT_W-1:0]  rec_inc;

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] v);
        return (v > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : v[CNT_W-1:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_ERR; gi++) begin : g_src
            assign src_active[gi] = ~err_n[gi];
        end
    endgenerate

    assign err_event = |src_active;
    assign tec_inc   = sat({1'b0, tec_reg} + (CNT_W+1)'(8));
    assign rec_inc   = sat({1'b0, rec_reg} + (CNT_W+1)'(1));

    assign err_state = busoff_reg ? 2'b10 :
                       (({1'b0, tec_reg} >= PASSIVE_THR) ||
                        ({1'b0, rec_reg} >= PASSIVE_THR)) ? 2'b01 : 2'b00;

    assign ERROR    = error_n_reg;
    assign flag_bit = ~((state_reg == ST_FLAG) && dom_flag_reg);
    assign err_src  = err_src_reg;
    assign tec      = tec_reg;
    assign rec      = rec_reg;

    always_comb begin
        state_next     = state_reg;
        flag_cnt_next  = flag_cnt_reg;
        delim_cnt_next = delim_cnt_reg;
        run_cnt_next   = run_cnt_reg;
        occ_cnt_next   = occ_cnt_reg;
        tec_next       = tec_reg;
        rec_next       = rec_reg;
        busoff_next    = busoff_reg;
        dom_flag_next  = dom_flag_reg;
        error_n_next   = 1'b1;
        err_src_next   = err_src_reg;

        case (state_reg)
            ST_IDLE: begin
                if (err_event) begin
                    // Flag polarity follows the confinement state the node
                    // was in when the error was seen, before this increment.
                    err_src_next  = src_active;
                    dom_flag_next = (err_state == 2'b00);
                    flag_cnt_next = '0;
                    if (is_tx) begin
                        tec_next = tec_inc;
                    end else begin
                        rec_next = rec_inc;
                    end
                    if (is_tx && ({1'b0, tec_inc} >= BUSOFF_THR)) begin
                        // Going bus-off: no flag and no ERROR pulse.
                        state_next   = ST_BUSOFF;
                        busoff_next  = 1'b1;
                        run_cnt_next = '0;
                        occ_cnt_next = '0;
                    end else begin
                        state_next   = ST_FLAG;
                        error_n_next = 1'b0;
                    end
                end else begin
                    if (tx_ok && (tec_reg != '0)) begin
                        tec_next = tec_reg - CNT_W'(1);
                    end
                    if (rx_ok) begin
                        if ({1'b0, rec_reg} >= PASSIVE_THR) begin
                            rec_next = REC_RESTORE;
                        end else if (rec_reg != '0) begin
                            rec_next = rec_reg - CNT_W'(1);
                        end
                    end
                end
            end

            ST_FLAG: begin
                if (flag_cnt_reg == FC_W'(FLAG_LEN - 1)) begin
                    state_next = ST_SUPERPOS;
                end else begin
                    flag_cnt_next = flag_cnt_reg + FC_W'(1);
                end
            end

            ST_SUPERPOS: begin
                // Other nodes may still be flagging. The first recessive
                // bit is already delimiter bit 1.
                if (bus_bit) begin
                    if (DELIM_LEN <= 1) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next     = ST_DELIM;
                        delim_cnt_next = DC_W'(1);
                    end
                end
            end

            ST_DELIM: begin
                if (bus_bit) begin
                    if (delim_cnt_reg == DC_W'(DELIM_LEN - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        delim_cnt_next = delim_cnt_reg + DC_W'(1);
                    end
                end else begin
                    delim_cnt_next = '0;
                end
            end

            ST_BUSOFF: begin
                if (bus_bit) begin
                    if (run_cnt_reg == RC_W'(RUN_LEN - 1)) begin
                        run_cnt_next = '0;
                        if (occ_cnt_reg == OC_W'(RECOV_SEQ - 1)) begin
                            occ_cnt_next = '0;
                            tec_next     = '0;
                            rec_next     = '0;
                            busoff_next  = 1'b0;
                            state_next   = ST_IDLE;
                        end else begin
                            occ_cnt_next = occ_cnt_reg + OC_W'(1);
                        end
                    end else begin
                        run_cnt_next = run_cnt_reg + RC_W'(1);
                    end
                end else begin
                    run_cnt_next = '0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SP or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            flag_cnt_reg  <= '0;
            delim_cnt_reg <= '0;
            run_cnt_reg   <= '0;
            occ_cnt_reg   <= '0;
            tec_reg       <= '0;
            rec_reg       <= '0;
            busoff_reg    <= 1'b0;
            dom_flag_reg  <= 1'b0;
            error_n_reg   <= 1'b1;
            err_src_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            flag_cnt_reg  <= flag_cnt_next;
            delim_cnt_reg <= delim_cnt_next;
            run_cnt_reg   <= run_cnt_next;
            occ_cnt_reg   <= occ_cnt_next;
            tec_reg       <= tec_next;
            rec_reg       <= rec_next;
            busoff_reg    <= busoff_next;
            dom_flag_reg  <= dom_flag_next;
            error_n_reg   <= error_n_next;
            err_src_reg   <= err_src_next;
        end
    end

endmodule

// File: doc/can_error_confinement.md
Name: can_error_confinement

Overview:
- Parametrised successor to the CAN decoder's single-bit error flagger.
- Merges N active-low error-detect sources into one error event.
- Maintains the CAN transmit and receive error counters (TEC/REC) and derives the error-active, error-passive and bus-off state.
- Sequences the error flag and error delimiter on the bus, and runs bus-off recovery.
- Clocked once per bit at the sample point. Sits between the decoder check blocks (stuff, CRC, form, EOF) and the bus driver.

Parameters:
- N_ERR, 4, number of active-low error-detect inputs.
- FLAG_LEN, 6, error flag length in bits.
- DELIM_LEN, 8, error delimiter length in recessive bits.
- CNT_W, 9, width of TEC/REC; counters saturate at 2^CNT_W-1.
- PASSIVE_LIM, 128, TEC or REC value at or above which the node is error-passive.
- BUSOFF_LIM, 256, TEC value at or above which the node is bus-off.
- RECOV_SEQ, 128, number of 11-recessive-bit sequences required to leave bus-off.

Ports:
- SP  in  1  sample-point clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- err_n  in  N_ERR  per-source error detect, active-low, sampled at SP.
- is_tx  in  1  1 = node is transmitter of the current frame, 0 = receiver.
- tx_ok  in  1  one-SP pulse: frame transmitted successfully.
- rx_ok  in  1  one-SP pulse: frame received successfully.
- bus_bit  in  1  sampled bus level; 0 = dominant.
- ERROR  out  1  active-low error pulse.
- flag_bit  out  1  level to drive on the bus; 0 = dominant, 1 = recessive/idle.
- err_src  out  N_ERR  latched copy of the sources (active-high) that caused the last error.
- err_state  out  2  00 = error-active, 01 = error-passive, 10 = bus-off.
- tec  out  CNT_W  transmit error counter.
- rec  out  CNT_W  receive error counter.

Behaviour:
- Reset values (asynchronous, immediate, also when asserted mid-flag): FSM=IDLE, ERROR=1, flag_bit=1, err_src=0, tec=0, rec=0, err_state=00, all internal counters 0.
- err_event = any bit of err_n equal to 0 at an SP edge.
- err_state is combinational from the counters:
  - 10 when the bus-off latch is set;
  - else 01 when tec>=PASSIVE_LIM or rec>=PASSIVE_LIM;
  - else 00.
- Bus-off latch sets when tec>=BUSOFF_LIM and clears only on recovery.
- FSM states:
  - IDLE: on err_event, go to FLAG. In the same edge: err_src<=~err_n; if is_tx, tec+=8, else rec+=1 (both saturating). The next cycle has ERROR=0 for exactly one SP. tx_ok: tec-=1 if >0. rx_ok: if rec>PASSIVE_LIM-1 then rec<=119, else rec-=1 if >0.
  - FLAG: FLAG_LEN cycles. flag_bit=0 if err_state was 00 at entry, else 1. Then go to SUPERPOS.
  - SUPERPOS: flag_bit=1; wait for bus_bit==1, then go to DELIM. That first recessive bit counts as delimiter bit 1.
  - DELIM: flag_bit=1; count recessive bits to DELIM_LEN total, then go to IDLE. A dominant bus_bit restarts the count at 0 with no counter change.
  - BUSOFF: entered from any state when the latch sets. flag_bit=1, ERROR=1, err_event ignored. On every 11th consecutive recessive bus_bit, increment the occurrence counter and restart the run count. A dominant bit clears only the run count. At RECOV_SEQ occurrences: tec=0, rec=0, latch clears, go to IDLE.
- err_event, tx_ok and rx_ok are ignored outside IDLE.
- An error and tx_ok/rx_ok on the same edge: the error wins; the ok pulse is discarded.
- If tec reaches BUSOFF_LIM on the error increment, skip FLAG and go straight to BUSOFF.
- Arithmetic is unsigned CNT_W; no wrap in either direction.

Test Plan:
- Reset, then err_n=4'b1011 at one SP with is_tx=0:
  - ERROR=0 for one SP, err_src=4'b0100, rec=1;
  - flag_bit=0 for 6 SPs, then 1;
  - back in IDLE after 8 recessive bits.
- Preload rec=127 via 127 receiver errors, then one more error:
  - rec=128, err_state=01;
  - the next error produces a recessive flag (flag_bit stays 1);
  - rx_ok then gives rec=119, err_state=00.
- 32 transmitter errors from tec=0:
  - tec=256, err_state=10, no flag, ERROR stays 1.
- From bus-off, drive 128×11 recessive bits with one dominant bit inserted mid-run:
  - recovery takes 1 run longer;
  - then tec=0, rec=0, err_state=00.
- Hold bus_bit=0 for 5 SPs after the flag: DELIM starts at the first recessive bit. A dominant bit at delimiter bit 4 restarts the count.
- Assert reset mid-FLAG: outputs return to reset values without waiting for an SP edge. Simultaneous err_event and tx_ok: tec increments by 8 only.
